de_pipe_reg: RTL

- ID/EX pipeline register. Captures decoded D-stage operands and controls on each clock, then drives the E stage.
- E stage consumers: the ALU (SrcA, SrcB source, Shamt, ALUOp), the E-stage forwarding muxes and the hazard unit.
- Inserts bubbles on D-stage stall, supports a synchronous flush, and carries a Tnew field for stall/forward decisions.

---
 rtl/de_pipe_reg.sv | 111 +++++++++++
 1 files changed

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: ID/EX pipeline register.
// Captures the decoded D-stage operands and controls on every rising clk edge.
// The registered copies feed the E stage: the ALU, the E-stage forwarding
// muxes and the hazard unit.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   stall              D is held this cycle, so E receives a bubble (E_PC keeps D_PC)
//   flush              synchronous clear of E (E_PC <= RESET_PC); overrides stall
//   D_*                decoded D-stage fields
//   E_*                registered copies of the D_* fields
//   E_SrcB             ALU B operand, E_ALUSrc ? E_EXT : E_RD2 (combinational)
//   E_valid            1 = E holds a real instruction, 0 = bubble
module de_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_RD2,
  input  logic [31:0] D_EXT,
  input  logic [4:0]  D_Shamt,
  input  logic [2:0]  D_ALUOp,
  input  logic        D_ALUSrc,
  input  logic [4:0]  D_A3,
  input  logic        D_RegWrite,
  input  logic [1:0]  D_Tnew,
  output logic [31:0] E_PC,
  output logic [31:0] E_Instr,
  output logic [31:0] E_RD1,
  output logic [31:0] E_RD2,
  output logic [31:0] E_EXT,
  output logic [4:0]  E_Shamt,
  output logic [2:0]  E_ALUOp,
  output logic        E_ALUSrc,
  output logic [4:0]  E_A3,
  output logic        E_RegWrite,
  output logic [1:0]  E_Tnew,
  output logic [31:0] E_SrcB,
  output logic        E_valid
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [4:0]  shamt;
    logic [2:0]  aluop;
    logic        alusrc;
    logic [4:0]  a3;
    logic        regwrite;
    logic [1:0]  tnew;
    logic        valid;
  } ex_t;

  ex_t e_q, e_d;

  // Priority: flush > stall > load.
  // A bubble is all zeros. Instr=0 decodes as sll $0,$0,0. A3=0 with
  // RegWrite=0 can neither write the GRF nor match a forward. Tnew=0
  // never stalls. Only the PC differs between the two bubble kinds.
  always_comb begin
    e_d          = '0;
    e_d.pc       = D_PC;
    if (flush) begin
      e_d.pc     = RESET_PC;
    end else if (!stall) begin
      e_d.instr    = D_Instr;
      e_d.rd1      = D_RD1;
      e_d.rd2      = D_RD2;
      e_d.ext      = D_EXT;
      e_d.shamt    = D_Shamt;
      e_d.aluop    = D_ALUOp;
      e_d.alusrc   = D_ALUSrc;
      e_d.a3       = D_A3;
      e_d.regwrite = D_RegWrite;
      e_d.tnew     = D_Tnew;  // passed unchanged; the E/M register decrements it
      e_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      e_q.pc <= RESET_PC;
    end else begin
      e_q    <= e_d;
    end
  end

  assign E_PC       = e_q.pc;
  assign E_Instr    = e_q.instr;
  assign E_RD1      = e_q.rd1;
  assign E_RD2      = e_q.rd2;
  assign E_EXT      = e_q.ext;
  assign E_Shamt    = e_q.shamt;
  assign E_ALUOp    = e_q.aluop;
  assign E_ALUSrc   = e_q.alusrc;
  assign E_A3       = e_q.a3;
  assign E_RegWrite = e_q.regwrite;
  assign E_Tnew     = e_q.tnew;
  assign E_valid    = e_q.valid;
  assign E_SrcB     = e_q.alusrc ? e_q.ext : e_q.rd2;

endmodule
